// File: rtl/vga_wb_regfile.sv
// Wishbone register file for the VGA/LCD controller: control, status, timing,
// CLUT base and N video bank base registers with bank/page switching.
module vga_wb_regfile #(
  parameter  int NBANKS = 2,
  localparam int BW     = $clog2(NBANKS)
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [5:2]    ADR_I,
  input  logic [31:0]   DAT_I,
  output logic [31:0]   DAT_O,
  input  logic [3:0]    SEL_I,
  input  logic          WE_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          INTA_O,
  output logic          ven,
  output logic          pc,
  output logic          hsl,
  output logic          vsl,
  output logic          csl,
  output logic          bl,
  output logic [1:0]    vbl,
  output logic [1:0]    cd,
  output logic [7:0]    Thsync,
  output logic [7:0]    Thgdel,
  output logic [7:0]    Tvsync,
  output logic [7:0]    Tvgdel,
  output logic [15:0]   Thgate,
  output logic [15:0]   Thlen,
  output logic [15:0]   Tvgate,
  output logic [15:0]   Tvlen,
  output logic [31:2]   vbar_o,
  output logic [BW-1:0] vbank_o,
  output logic [31:11]  cbar_o,
  output logic          cpage_o,
  input  logic          bs_in,
  input  logic          hint_in,
  input  logic          vint_in,
  input  logic          luint_in,
  input  logic          sint_in
);

  logic [16:0]   ctrl_q, ctrl_d;
  logic          sint_q, luint_q, vint_q, hint_q, bsint_q;
  logic [31:0]   htim_q, vtim_q, hvlen_q;
  logic [31:11]  cbar_q;
  logic [31:2]   vbar_q [NBANKS];
  logic [BW-1:0] vbank_q, vbank_d;
  logic          cpage_q, cpage_d;
  logic          bs_hit;

  logic          access, mapped, wr;
  logic [4:0]    adr_x;
  logic [BW-1:0] vidx;
  logic [31:0]   lane_mask, rd_data;
  logic [7:0]    w1c;
  logic          irq;

  // A new access only starts once the previous termination has dropped,
  // which gives one termination every second cycle for a held strobe.
  assign access    = CYC_I && STB_I && !ACK_O && !ERR_O;
  assign adr_x     = {1'b0, ADR_I};
  assign mapped    = (adr_x < 5'd6) || ((adr_x >= 5'd8) && (adr_x < 5'(8 + NBANKS)));
  assign wr        = access && mapped && WE_I;
  assign vidx      = ADR_I[BW+1:2];
  assign lane_mask = {{8{SEL_I[3]}}, {8{SEL_I[2]}}, {8{SEL_I[1]}}, {8{SEL_I[0]}}};
  assign w1c       = (wr && ADR_I == 4'd1) ? (DAT_I[7:0] & lane_mask[7:0]) : 8'h00;

  assign irq = |({sint_q, luint_q, vint_q, hint_q, bsint_q} &
                 {ctrl_q[7], ctrl_q[6], ctrl_q[1], ctrl_q[2], ctrl_q[3]});

  always_comb begin
    rd_data = '0;
    case (ADR_I)
      4'd0: rd_data = {15'b0, ctrl_q};
      4'd1: begin
        rd_data[0]       = sint_q;
        rd_data[1]       = luint_q;
        rd_data[4]       = vint_q;
        rd_data[5]       = hint_q;
        rd_data[6]       = bsint_q;
        rd_data[16 +: BW] = vbank_q;
        rd_data[19]      = cpage_q;
      end
      4'd2: rd_data = htim_q;
      4'd3: rd_data = vtim_q;
      4'd4: rd_data = hvlen_q;
      4'd5: rd_data = {cbar_q, cpage_q, 10'b0};
      default: if (ADR_I[5]) rd_data = {vbar_q[vidx], 2'b00};
    endcase
  end

  // Bank switch acts on pre-edge CTRL; a host CTRL write on the same edge
  // still lands on top of the cleared switch bits.
  always_comb begin
    ctrl_d  = ctrl_q;
    vbank_d = vbank_q;
    cpage_d = cpage_q;
    bs_hit  = 1'b0;
    if (bs_in && ctrl_q[4]) begin
      vbank_d   = vbank_q + BW'(1);
      ctrl_d[4] = 1'b0;
      bs_hit    = 1'b1;
    end
    if (bs_in && ctrl_q[5]) begin
      cpage_d   = ~cpage_q;
      ctrl_d[5] = 1'b0;
      bs_hit    = 1'b1;
    end
    if (wr && ADR_I == 4'd0)
      ctrl_d = (ctrl_d & ~lane_mask[16:0]) | (DAT_I[16:0] & lane_mask[16:0]);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ACK_O   <= 1'b0;
      ERR_O   <= 1'b0;
      DAT_O   <= '0;
      INTA_O  <= 1'b0;
      ctrl_q  <= '0;
      sint_q  <= 1'b0;
      luint_q <= 1'b0;
      vint_q  <= 1'b0;
      hint_q  <= 1'b0;
      bsint_q <= 1'b0;
      htim_q  <= '0;
      vtim_q  <= '0;
      hvlen_q <= '0;
      cbar_q  <= '0;
      vbank_q <= '0;
      cpage_q <= 1'b0;
      for (int i = 0; i < NBANKS; i++) vbar_q[i] <= '0;
    end else begin
      ACK_O   <= access && mapped;
      ERR_O   <= access && !mapped;
      DAT_O   <= (access && mapped) ? rd_data : '0;
      INTA_O  <= irq;
      ctrl_q  <= ctrl_d;
      vbank_q <= vbank_d;
      cpage_q <= cpage_d;
      // Set beats a concurrent write-1-to-clear.
      sint_q  <= sint_in  || (sint_q  && !w1c[0]);
      luint_q <= luint_in || (luint_q && !w1c[1]);
      vint_q  <= vint_in  || (vint_q  && !w1c[4]);
      hint_q  <= hint_in  || (hint_q  && !w1c[5]);
      bsint_q <= bs_hit   || (bsint_q && !w1c[6]);
      if (wr && ADR_I == 4'd2) htim_q  <= (htim_q  & ~lane_mask) | (DAT_I & lane_mask);
      if (wr && ADR_I == 4'd3) vtim_q  <= (vtim_q  & ~lane_mask) | (DAT_I & lane_mask);
      if (wr && ADR_I == 4'd4) hvlen_q <= (hvlen_q & ~lane_mask) | (DAT_I & lane_mask);
      if (wr && ADR_I == 4'd5)
        cbar_q <= (cbar_q & ~lane_mask[31:11]) | (DAT_I[31:11] & lane_mask[31:11]);
      for (int i = 0; i < NBANKS; i++)
        if (wr && ADR_I[5] && vidx == BW'(i))
          vbar_q[i] <= (vbar_q[i] & ~lane_mask[31:2]) | (DAT_I[31:2] & lane_mask[31:2]);
    end
  end

  assign ven     = ctrl_q[0];
  assign vbl     = ctrl_q[9:8];
  assign cd      = ctrl_q[11:10];
  assign pc      = ctrl_q[12];
  assign hsl     = ctrl_q[13];
  assign vsl     = ctrl_q[14];
  assign csl     = ctrl_q[15];
  assign bl      = ctrl_q[16];
  assign Thsync  = htim_q[31:24];
  assign Thgdel  = htim_q[23:16];
  assign Thgate  = htim_q[15:0];
  assign Tvsync  = vtim_q[31:24];
  assign Tvgdel  = vtim_q[23:16];
  assign Tvgate  = vtim_q[15:0];
  assign Thlen   = hvlen_q[31:16];
  assign Tvlen   = hvlen_q[15:0];
  assign cbar_o  = cbar_q;
  assign cpage_o = cpage_q;
  assign vbank_o = vbank_q;
  assign vbar_o  = vbar_q[vbank_q];

endmodule

// File: tb/tb_vga_wb_regfile.sv
// Bench for vga_wb_regfile: register-image model compared every cycle,
// plus directed sequences with hand-computed expectations.
module tb_vga_wb_regfile;
  localparam int NB = 4;

  logic        CLK_I = 1'b0, RST_I = 1'b1;
  logic [5:2]  ADR_I = '0;
  logic [31:0] DAT_I = '0, DAT_O;
  logic [3:0]  SEL_I = '0;
  logic        WE_I = 1'b0, STB_I = 1'b0, CYC_I = 1'b0;
  logic        ACK_O, ERR_O, INTA_O;
  logic        ven, pc, hsl, vsl, csl, bl;
  logic [1:0]  vbl, cd;
  logic [7:0]  Thsync, Thgdel, Tvsync, Tvgdel;
  logic [15:0] Thgate, Thlen, Tvgate, Tvlen;
  logic [31:2] vbar_o;
  logic [1:0]  vbank_o;
  logic [31:11] cbar_o;
  logic        cpage_o;
  logic        bs_in = 1'b0, hint_in = 1'b0, vint_in = 1'b0, luint_in = 1'b0, sint_in = 1'b0;

  vga_wb_regfile #(.NBANKS(NB)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O),
    .SEL_I(SEL_I), .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I),
    .ACK_O(ACK_O), .ERR_O(ERR_O), .INTA_O(INTA_O),
    .ven(ven), .pc(pc), .hsl(hsl), .vsl(vsl), .csl(csl), .bl(bl), .vbl(vbl), .cd(cd),
    .Thsync(Thsync), .Thgdel(Thgdel), .Tvsync(Tvsync), .Tvgdel(Tvgdel),
    .Thgate(Thgate), .Thlen(Thlen), .Tvgate(Tvgate), .Tvlen(Tvlen),
    .vbar_o(vbar_o), .vbank_o(vbank_o), .cbar_o(cbar_o), .cpage_o(cpage_o),
    .bs_in(bs_in), .hint_in(hint_in), .vint_in(vint_in), .luint_in(luint_in), .sint_in(sint_in)
  );

  always #5 CLK_I = ~CLK_I;

  int total = 0, bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: registers held as their host-visible read images.
  logic [31:0] m_ctrl = '0, m_stat = '0, m_htim = '0, m_vtim = '0, m_hvlen = '0, m_cbar = '0;
  logic [31:0] m_vbar [NB];
  int          m_vbank = 0;
  bit          m_cpage = 1'b0;
  logic        e_ack = 1'b0, e_err = 1'b0, e_inta = 1'b0;
  logic [31:0] e_dat = '0;

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0: return m_ctrl;
      1: return m_stat | 32'(m_vbank << 16) | (m_cpage ? 32'h0008_0000 : 32'h0);
      2: return m_htim;
      3: return m_vtim;
      4: return m_hvlen;
      5: return m_cbar | (m_cpage ? 32'h0000_0400 : 32'h0);
      default: return (a >= 8 && a < 8 + NB) ? m_vbar[a-8] : 32'h0;
    endcase
  endfunction

  always @(posedge CLK_I) begin : model
    logic [31:0] c, s, mask, d;
    bit acc, mp, w, bsh, irq;
    int a;
    a = int'(ADR_I);
    if (RST_I) begin
      m_ctrl = 0; m_stat = 0; m_htim = 0; m_vtim = 0; m_hvlen = 0; m_cbar = 0;
      for (int i = 0; i < NB; i++) m_vbar[i] = 0;
      m_vbank = 0; m_cpage = 0; e_ack = 0; e_err = 0; e_inta = 0; e_dat = 0;
    end else begin
      acc  = CYC_I && STB_I && !e_ack && !e_err;
      mp   = (a < 6) || (a >= 8 && a < 8 + NB);
      w    = acc && mp && WE_I;
      mask = {{8{SEL_I[3]}}, {8{SEL_I[2]}}, {8{SEL_I[1]}}, {8{SEL_I[0]}}};
      d    = DAT_I & mask;
      irq  = (m_stat[0] && m_ctrl[7]) || (m_stat[1] && m_ctrl[6]) || (m_stat[4] && m_ctrl[1]) ||
             (m_stat[5] && m_ctrl[2]) || (m_stat[6] && m_ctrl[3]);
      e_dat  = (acc && mp) ? m_read(a) : 32'h0;
      e_ack  = acc && mp;
      e_err  = acc && !mp;
      e_inta = irq;
      c = m_ctrl; bsh = 0;
      if (bs_in && m_ctrl[4]) begin m_vbank = (m_vbank + 1) % NB; c[4] = 0; bsh = 1; end
      if (bs_in && m_ctrl[5]) begin m_cpage = !m_cpage; c[5] = 0; bsh = 1; end
      if (w && a == 0) c = ((c & ~mask) | d) & 32'h0001_FFFF;
      s = m_stat;
      if (w && a == 1) s = s & ~d;
      s = (s | {25'b0, bsh, hint_in, vint_in, 2'b0, luint_in, sint_in}) & 32'h73;
      m_ctrl = c; m_stat = s;
      if (w && a == 2) m_htim  = (m_htim  & ~mask) | d;
      if (w && a == 3) m_vtim  = (m_vtim  & ~mask) | d;
      if (w && a == 4) m_hvlen = (m_hvlen & ~mask) | d;
      if (w && a == 5) m_cbar  = ((m_cbar & ~mask) | d) & 32'hFFFF_F800;
      if (w && a >= 8) m_vbar[a-8] = ((m_vbar[a-8] & ~mask) | d) & 32'hFFFF_FFFC;
    end
  end

  always @(negedge CLK_I) begin
    if (cmp_en) begin
      chk("m_ack",   32'(ACK_O),  32'(e_ack));
      chk("m_err",   32'(ERR_O),  32'(e_err));
      chk("m_dat",   DAT_O,       e_dat);
      chk("m_inta",  32'(INTA_O), 32'(e_inta));
      chk("m_ctrl",  {15'b0, bl, csl, vsl, hsl, pc, cd, vbl, 7'b0, ven}, m_ctrl & 32'h0001_FF01);
      chk("m_htim",  {Thsync, Thgdel, Thgate}, m_htim);
      chk("m_vtim",  {Tvsync, Tvgdel, Tvgate}, m_vtim);
      chk("m_hvlen", {Thlen, Tvlen}, m_hvlen);
      chk("m_cbar",  {cbar_o, 11'b0}, m_cbar);
      chk("m_cpage", 32'(cpage_o), 32'(m_cpage));
      chk("m_vbank", 32'(vbank_o), 32'(m_vbank));
      chk("m_vbar",  {vbar_o, 2'b00}, m_vbar[m_vbank]);
    end
  end

  // One bus/event cycle; outputs sampled 1 time unit after the terminating edge.
  task automatic cyc(input bit acc, input bit we, input logic [3:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [4:0] ev, input bit rst,
                     output logic [31:0] rd, output logic ack, output logic err);
    @(negedge CLK_I);
    CYC_I = acc; STB_I = acc; WE_I = we; ADR_I = adr; DAT_I = dat; SEL_I = sel; RST_I = rst;
    {bs_in, hint_in, vint_in, luint_in, sint_in} = ev;
    @(posedge CLK_I); #1;
    rd = DAT_O; ack = ACK_O; err = ERR_O;
    @(negedge CLK_I);
    CYC_I = 0; STB_I = 0; WE_I = 0; RST_I = 0;
    {bs_in, hint_in, vint_in, luint_in, sint_in} = 5'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                    input logic [4:0] ev);
    logic [31:0] r; logic a, e;
    cyc(1, 1, adr, dat, sel, ev, 0, r, a, e);
    chk("wr_ack", 32'(a), 32'd1);
  endtask

  task automatic rdchk(input string nm, input logic [3:0] adr, input logic [31:0] exp);
    logic [31:0] r; logic a, e;
    cyc(1, 0, adr, 32'h0, 4'hF, 5'b0, 0, r, a, e);
    chk({nm, "_ack"}, 32'(a), 32'd1);
    chk(nm, r, exp);
  endtask

  task automatic pulse(input logic [4:0] ev);
    logic [31:0] r; logic a, e;
    cyc(0, 0, 4'd0, 32'h0, 4'h0, ev, 0, r, a, e);
  endtask

  localparam logic [4:0] EV_BS = 5'b10000, EV_V = 5'b00100;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] r; logic a, e; int n; bit mp;
    repeat (2) @(posedge CLK_I);
    @(negedge CLK_I);
    RST_I = 0;
    cmp_en = 1;

    for (int ad = 0; ad < 16; ad++) begin
      cyc(1, 0, 4'(ad), 32'h0, 4'hF, 5'b0, 0, r, a, e);
      mp = (ad < 6) || (ad >= 8 && ad < 12);
      chk("rst_rd_ack", 32'(a), 32'(mp));
      chk("rst_rd_err", 32'(e), 32'(!mp));
      chk("rst_rd_dat", r, 32'h0);
    end

    wr(4'd9, 32'hA5A5_5A5F, 4'b0011, 5'b0);
    rdchk("vbar1_rd", 4'd9, 32'h0000_5A5C);
    chk("vbar_o_bank0", {vbar_o, 2'b00}, 32'h0);

    wr(4'd0, 32'h18, 4'hF, 5'b0);
    pulse(EV_BS);
    chk("vbank_first", 32'(vbank_o), 32'd1);
    chk("inta_not_yet", 32'(INTA_O), 32'd0);
    @(posedge CLK_I); #1;
    chk("inta_bs", 32'(INTA_O), 32'd1);
    rdchk("stat_bs", 4'd1, 32'h0001_0040);
    for (int k = 2; k <= 4; k++) begin
      wr(4'd0, 32'h18, 4'hF, 5'b0);
      pulse(EV_BS);
      chk("vbank_seq", 32'(vbank_o), 32'(k % 4));
    end

    wr(4'd1, 32'h40, 4'b0001, 5'b0);
    rdchk("stat_bs_clr", 4'd1, 32'h0);
    wr(4'd0, 32'h02, 4'hF, 5'b0);
    pulse(EV_V);
    @(posedge CLK_I); #1;
    chk("inta_vint", 32'(INTA_O), 32'd1);
    wr(4'd1, 32'h10, 4'b0001, EV_V);
    rdchk("stat_set_wins", 4'd1, 32'h10);
    wr(4'd1, 32'h10, 4'b0001, 5'b0);
    chk("inta_at_clr", 32'(INTA_O), 32'd1);
    @(posedge CLK_I); #1;
    chk("inta_cleared", 32'(INTA_O), 32'd0);
    rdchk("stat_vint_clr", 4'd1, 32'h0);

    wr(4'd0, 32'h10, 4'hF, 5'b0);
    wr(4'd0, 32'h10, 4'hF, EV_BS);
    chk("vbank_adv_wr", 32'(vbank_o), 32'd1);
    rdchk("ctrl_keep", 4'd0, 32'h10);
    rdchk("stat_bs2", 4'd1, 32'h0001_0040);

    wr(4'd0, 32'h20, 4'hF, 5'b0);
    pulse(EV_BS);
    chk("cpage_tgl", 32'(cpage_o), 32'd1);
    chk("vbank_hold", 32'(vbank_o), 32'd1);
    wr(4'd5, 32'hFFFF_FFFF, 4'hF, 5'b0);
    rdchk("cbar_rd", 4'd5, 32'hFFFF_FC00);
    rdchk("ctrl_sw_clr", 4'd0, 32'h0);

    wr(4'd2, 32'h1234_5678, 4'hF, 5'b0);
    chk("thsync", 32'(Thsync), 32'h12);
    chk("thgate", 32'(Thgate), 32'h5678);
    wr(4'd4, 32'hAABB_CCDD, 4'b0100, 5'b0);
    rdchk("hvlen_lane", 4'd4, 32'h00BB_0000);
    chk("thlen", 32'(Thlen), 32'h00BB);
    wr(4'd3, 32'hDEAD_BEEF, 4'b1000, 5'b0);
    chk("tvsync", 32'(Tvsync), 32'hDE);
    chk("tvgate", 32'(Tvgate), 32'h0);

    cyc(1, 1, 4'd6, 32'hFFFF_FFFF, 4'hF, 5'b0, 0, r, a, e);
    chk("unmap_err", 32'(e), 32'd1);
    chk("unmap_ack", 32'(a), 32'd0);
    cyc(1, 1, 4'd13, 32'hFFFF_FFFF, 4'hF, 5'b0, 0, r, a, e);
    chk("unmap13_err", 32'(e), 32'd1);

    @(negedge CLK_I);
    CYC_I = 1; STB_I = 1; WE_I = 0; ADR_I = 4'd2;
    n = 0;
    repeat (4) begin
      @(posedge CLK_I); #1;
      if (ACK_O) n++;
    end
    @(negedge CLK_I);
    CYC_I = 0; STB_I = 0;
    chk("held_acks", 32'(n), 32'd2);

    wr(4'd0, 32'h08, 4'hF, 5'b0);
    @(posedge CLK_I); #1;
    chk("inta_pre_rst", 32'(INTA_O), 32'd1);
    cyc(1, 1, 4'd0, 32'h0001_FFFF, 4'hF, 5'b0, 1, r, a, e);
    chk("rst_noack", 32'(a), 32'd0);
    chk("rst_dat", r, 32'h0);
    chk("rst_inta", 32'(INTA_O), 32'd0);
    chk("rst_vbank", 32'(vbank_o), 32'd0);
    chk("rst_cpage", 32'(cpage_o), 32'd0);
    chk("rst_thsync", 32'(Thsync), 32'd0);
    chk("rst_cbar", {cbar_o, 11'b0}, 32'h0);
    rdchk("ctrl_after_rst", 4'd0, 32'h0);

    repeat (2) @(posedge CLK_I);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
